// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU sharing controller: opcodes, FSM encoding
// and a couple of small decode helpers used by the controller.
package alu_ctrl_pkg;

  // ALU opcodes that the controller or its users care about by name
  localparam logic [3:0] OP_INV = 4'b0000;
  localparam logic [3:0] OP_RR  = 4'b1000;
  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  // Controller FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Opcodes 4'b1100..4'b1111 have no ALU function and are flagged as errors
  function automatic logic is_err_op(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

  // Extra EXEC cycles needed before the ALU outputs are settled
  function automatic logic [1:0] exec_wait(input logic [3:0] op, input int mul_wait);
    logic [1:0] w;
    w = 2'(mul_wait);
    return (op == OP_MUL) ? w : 2'd0;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the requesting engines and the ALU
// sharing controller. master = requesters + response consumer,
// slave = the controller.
interface alu_share_ctrl_if #(parameter int N_REQ = 2);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [4*N_REQ-1:0] req_op;
  logic [8*N_REQ-1:0] req_a;
  logic [8*N_REQ-1:0] req_b;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [7:0]         rsp_result;
  logic [15:0]        rsp_product;
  logic               rsp_of;
  logic               rsp_zero;
  logic               rsp_slt;
  logic               rsp_err;
  logic               busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_product,
           rsp_of, rsp_zero, rsp_slt, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_product,
           rsp_of, rsp_zero, rsp_slt, rsp_err, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches the request vector starting
// one past the previous winner, wrapping around, and returns a one-hot
// grant plus its index. The previous-winner register lives in the caller.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       grant_idx
);

  logic found;
  int   idx;

  // Walk the requesters in rotated priority order and take the first one
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares a single ALU8bit (instantiated in the parent) between N_REQ
// requesters. One request is in flight at a time: IDLE grants and latches
// operands, EXEC waits for the ALU to settle, RESP holds the captured
// result until the consumer takes it.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int MUL_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_ctrl_if.slave      bus,
  output logic [3:0]           alu_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  input  logic [7:0]           alu_result,
  input  logic [15:0]          alu_product,
  input  logic                 alu_of,
  input  logic                 alu_zero,
  input  logic                 alu_slt
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       wait_q, wait_d;
  logic [1:0]       last_grant_q;
  logic [3:0]       alu_op_q;
  logic [7:0]       alu_a_q, alu_b_q;
  logic [1:0]       rsp_id_q;
  logic [7:0]       rsp_result_q;
  logic [15:0]      rsp_product_q;
  logic             rsp_of_q, rsp_zero_q, rsp_slt_q, rsp_err_q;

  logic [N_REQ-1:0] grant;
  logic [1:0]       grant_idx;
  logic             any_req;
  logic [3:0]       sel_op;
  logic [7:0]       sel_a, sel_b;
  logic             accept;
  logic             capture;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign any_req = |bus.req_valid;
  assign accept  = (state_q == S_IDLE) && any_req;
  assign capture = (state_q == S_EXEC) && (wait_q == 2'd0);

  // Pick the winning requester's opcode and operands out of the flat buses
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_op = bus.req_op[i*4 +: 4];
        sel_a  = bus.req_a[i*8 +: 8];
        sel_b  = bus.req_b[i*8 +: 8];
      end
    end
  end

  // FSM next state and settle-counter update
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_EXEC;
          wait_d  = exec_wait(sel_op, MUL_WAIT);
        end
      end
      S_EXEC: begin
        if (wait_q == 2'd0) begin
          state_d = S_RESP;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight op and restarts priority at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_q       <= 2'd0;
      last_grant_q <= 2'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        last_grant_q <= grant_idx;
      end
    end
  end

  // Latch ALU drive on grant and capture ALU outputs once they have settled
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_q      <= 4'b1111;
      alu_a_q       <= 8'h00;
      alu_b_q       <= 8'h00;
      rsp_id_q      <= 2'd0;
      rsp_result_q  <= 8'h00;
      rsp_product_q <= 16'h0000;
      rsp_of_q      <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_slt_q     <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      if (accept) begin
        alu_op_q <= sel_op;
        alu_a_q  <= sel_a;
        alu_b_q  <= sel_b;
        rsp_id_q <= grant_idx;
      end
      if (capture) begin
        rsp_result_q  <= alu_result;
        rsp_product_q <= alu_product;
        rsp_of_q      <= alu_of;
        rsp_zero_q    <= alu_zero;
        rsp_slt_q     <= alu_slt;
        rsp_err_q     <= is_err_op(alu_op_q);
      end
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE) ? grant : '0;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_of      = rsp_of_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_slt     = rsp_slt_q;
  assign bus.rsp_err     = rsp_err_q;

  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a behavioural ALU model in place of ALU8bit.
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  localparam int NREQ = 2;
  localparam int MULW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.N_REQ(NREQ)) bus ();

  logic [3:0]  aluOp;
  logic [7:0]  aluA, aluB, aluResult;
  logic [15:0] aluProduct;
  logic        aluOf, aluZero, aluSlt;

  alu_share_ctrl #(.N_REQ(NREQ), .MUL_WAIT(MULW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alu_op      (aluOp),
    .alu_a       (aluA),
    .alu_b       (aluB),
    .alu_result  (aluResult),
    .alu_product (aluProduct),
    .alu_of      (aluOf),
    .alu_zero    (aluZero),
    .alu_slt     (aluSlt)
  );

  // Behavioural stand-in for the shared ALU
  always_comb begin
    aluResult  = 8'h00;
    aluProduct = 16'h0000;
    aluOf      = 1'b0;
    aluSlt     = 1'b0;
    case (aluOp)
      OP_INV:  aluResult = ~aluA;
      4'b0001: aluResult = aluA & aluB;
      4'b0010: aluResult = aluA | aluB;
      4'b0011: aluResult = aluA ^ aluB;
      OP_RR:   aluResult = {aluA[0], aluA[7:1]};
      OP_ADD: begin
        aluResult = aluA + aluB;
        aluOf     = (aluA[7] == aluB[7]) && (aluResult[7] != aluA[7]);
      end
      OP_SUB: begin
        aluResult = aluA - aluB;
        aluOf     = (aluA[7] != aluB[7]) && (aluResult[7] != aluA[7]);
        aluSlt    = ($signed(aluA) < $signed(aluB));
      end
      OP_MUL: aluProduct = $signed({{8{aluA[7]}}, aluA}) * $signed({{8{aluB[7]}}, aluB});
      default: ;
    endcase
    aluZero = (aluResult == 8'h00);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  result;
    logic [15:0] product;
    logic        of;
    logic        zero;
    logic        slt;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [7:0]  result;
    logic [15:0] product;
    logic        of;
    logic        zero;
    logic        slt;
    logic        err;
    int          tReady;
    int          lat;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[10];

  function automatic vec_t mkVec(int id, logic [3:0] op, logic [7:0] a, logic [7:0] b,
                                 logic [7:0] r, logic [15:0] p, logic of, logic z,
                                 logic s, logic e, int lat);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b; v.result = r; v.product = p;
    v.of = of; v.zero = z; v.slt = s; v.err = e; v.lat = lat;
    return v;
  endfunction

  function automatic exp_t mkExp(vec_t v, int tReady);
    exp_t e;
    e.id = 2'(v.id); e.result = v.result; e.product = v.product;
    e.of = v.of; e.zero = v.zero; e.slt = v.slt; e.err = v.err;
    e.tReady = tReady; e.lat = v.lat;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expireBound(input string name);
    checkCount++;
    $display("[TB] FAIL %s: timed out waiting, expected DUT event", name);
  endtask

  task automatic drivePayload(input vec_t v);
    bus.req_op[v.id*4 +: 4] = v.op;
    bus.req_a[v.id*8 +: 8]  = v.a;
    bus.req_b[v.id*8 +: 8]  = v.b;
    bus.req_valid[v.id]     = 1'b1;
  endtask

  // Pop the oldest expected response and compare it with what is presented
  task automatic compareRsp(input string name);
    exp_t e;
    if (sbQ.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL %s: got unexpected response, expected none", name);
    end else begin
      e = sbQ.pop_front();
      check(name, {2'b00, bus.rsp_id, bus.rsp_result, bus.rsp_product,
                   bus.rsp_of, bus.rsp_zero, bus.rsp_slt, bus.rsp_err},
                  {2'b00, e.id, e.result, e.product, e.of, e.zero, e.slt, e.err});
      check({name, " latency"}, 32'(cyc - e.tReady), 32'(e.lat));
    end
  endtask

  // Raise a request, wait for its grant, push its expectation, then withdraw it
  task automatic applyStimulus(input vec_t v, input string name);
    bit ok;
    ok = 1'b0;
    drivePayload(v);
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus.req_ready[v.id]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, " grant"}, 32'(bus.req_ready), 32'(1 << v.id));
    if (ok) sbQ.push_back(mkExp(v, cyc));
    @(posedge clk);
    #1;
    bus.req_valid[v.id] = 1'b0;
  endtask

  // Wait (bounded) for the next response and score it
  task automatic checkOutput(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) compareRsp(name);
    else expireBound(name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vA, vB, vM;
    logic [NREQ-1:0] grants[6];
    int gCyc[6];
    int g, rspSeen;
    bit seen;

    vecs[0] = mkVec(0, OP_ADD,  8'h05, 8'h03, 8'h08, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    vecs[1] = mkVec(1, OP_SUB,  8'h03, 8'h05, 8'hFE, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    vecs[2] = mkVec(0, OP_MUL,  8'hFD, 8'h04, 8'h00, 16'hFFF4, 1'b0, 1'b1, 1'b0, 1'b0, 2 + MULW);
    vecs[3] = mkVec(1, OP_ADD,  8'h7F, 8'h01, 8'h80, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    vecs[4] = mkVec(0, OP_SUB,  8'h80, 8'h01, 8'h7F, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    vecs[5] = mkVec(1, 4'b1101, 8'h12, 8'h34, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2);
    vecs[6] = mkVec(0, OP_ADD,  8'hFF, 8'h01, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    vecs[7] = mkVec(1, 4'b1111, 8'hAA, 8'h55, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 2);
    vecs[8] = mkVec(0, OP_RR,   8'h03, 8'h00, 8'h81, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    vecs[9] = mkVec(1, OP_MUL,  8'h10, 8'h10, 8'h00, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b0, 2 + MULW);
    vA = mkVec(0, OP_ADD, 8'h01, 8'h01, 8'h02, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    vB = mkVec(1, OP_ADD, 8'h02, 8'h02, 8'h04, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    vM = vecs[2];

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    check("reset req_ready", 32'(bus.req_ready), 32'h0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset alu drive", {12'h000, aluOp, aluA, aluB}, {12'h000, 4'hF, 8'h00, 8'h00});
    check("reset rsp regs", {2'b00, bus.rsp_id, bus.rsp_result, bus.rsp_product,
                             bus.rsp_of, bus.rsp_zero, bus.rsp_slt, bus.rsp_err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single ops
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d rsp", i));
      if (i == 0) begin
        @(negedge clk);
        #1;
        check("busy after first rsp", 32'(bus.busy), 32'h0);
      end
    end

    // Both requesters contend for six ops
    drivePayload(vA);
    drivePayload(vB);
    g = 0;
    rspSeen = 0;
    for (int j = 0; j < 6; j++) begin
      grants[j] = '0;
      gCyc[j] = 0;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid) begin
        compareRsp($sformatf("arb rsp%0d", rspSeen));
        rspSeen++;
      end
      if (bus.req_ready != '0 && g < 6) begin
        grants[g] = bus.req_ready;
        gCyc[g] = cyc;
        sbQ.push_back(mkExp((bus.req_ready == 2'b10) ? vB : vA, cyc));
        g++;
      end
      if (g == 6 && rspSeen == 6) break;
    end
    bus.req_valid = '0;
    for (int j = 0; j < 6; j++)
      check($sformatf("arb order%0d", j), 32'(grants[j]), (j % 2 == 0) ? 32'h1 : 32'h2);
    for (int j = 1; j < 6; j++)
      check($sformatf("arb spacing%0d", j), 32'(gCyc[j] - gCyc[j-1]), 32'd3);

    // Response back-pressure: outputs hold, no new grants
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    drivePayload(vA);
    drivePayload(vB);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) expireBound("stall rsp");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall cycle%0d", k),
            {19'h0, bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.rsp_result},
            {19'h0, 1'b1, 2'b00, 2'd0, 8'h02});
      @(negedge clk);
      #1;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("stall drain busy", 32'(bus.busy), 32'h0);

    // Reset during a multiply's EXEC drops it and restores priority
    applyStimulus(vM, "reset mul");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset mid-exec", {26'h0, bus.busy, bus.rsp_valid, aluOp}, {26'h0, 1'b0, 1'b0, 4'hF});
    @(negedge clk);
    rst = 1'b0;
    sbQ.delete();
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("post-reset quiet%0d", k), {30'h0, bus.busy, bus.rsp_valid}, 32'h0);
      @(negedge clk);
    end
    drivePayload(vA);
    drivePayload(vB);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.req_ready != '0) break;
      @(negedge clk);
    end
    check("post-reset grant", 32'(bus.req_ready), 32'h1);
    if (bus.req_ready == 2'b01) sbQ.push_back(mkExp(vA, cyc));
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    checkOutput("post-reset rsp");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequential controller that shares one `ALU8bit` instance among `N_REQ` requesters. It accepts operation requests over per-requester valid/ready handshakes and arbitrates between them round-robin. It drives the ALU from registered operands, waits the op-dependent settle time, and returns registered result, product and flags on a single tagged response channel. It sits between the requesting engines and the shared ALU; the ALU is instantiated in the parent and wired through the `alu_*` ports.

## Interface

- `N_REQ`, default 2, number of requesters (2..4)
- `MUL_WAIT`, default 1, extra EXEC cycles for multiply (0..3)

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in N_REQ: request pending, one bit per requester
- `req_ready` out N_REQ: one-hot grant pulse; the request is accepted when valid && ready
- `req_op` in 4*N_REQ: opcode, slice i belongs to requester i
- `req_a`, `req_b` in 8*N_REQ: operands, slice i belongs to requester i
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: consumer accepts response
- `rsp_id` out 2: index of the requester served
- `rsp_result` out 8, `rsp_product` out 16: captured ALU result and product
- `rsp_of`, `rsp_zero`, `rsp_slt` out 1 each: captured ALU flags
- `rsp_err` out 1: opcode was 4'b1100..4'b1111
- `busy` out 1: state != IDLE
- `alu_op` out 4, `alu_a` out 8, `alu_b` out 8: registered ALU drive
- `alu_result` in 8, `alu_product` in 16, `alu_of`, `alu_zero`, `alu_slt` in 1: ALU outputs

## Operation

- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - If any `req_valid` is high, the round-robin arbiter picks index g, searching from `last_grant+1` with wrap-around.
  - `req_ready[g]` is 1 for this cycle only.
  - The block registers `req_op/a/b[g]` into `alu_op/a/b`, sets `last_grant` to g and `rsp_id` to g, then moves to EXEC.
  - If no request is valid, the block stays in IDLE and `req_ready` is 0.
- **EXEC**
  - The wait counter loads 0 for all ops except multiply (4'b1011), which loads `MUL_WAIT`.
  - The counter decrements each cycle.
  - When the counter is 0, the block captures the `alu_*` outputs into the `rsp_*` registers and moves to RESP.
  - `rsp_err` is set to (`alu_op[3:2]` == 2'b11).
- **RESP**
  - `rsp_valid` is 1.
  - When `rsp_ready` is high, the block returns to IDLE.
  - The `rsp_*` outputs stay stable while `rsp_valid && !rsp_ready`.
- `req_ready` is 0 in EXEC and RESP; no request is accepted while one is in flight.
- Requesters must hold `req_valid` and their payload stable until granted. Dropping `req_valid` before the grant is legal and is not an error.
- Invalid opcodes still execute. The ALU default case produces result 0 and product 0, and `rsp_err` is 1.
- Flags are passed through unmodified from the ALU. This includes the multiply case, where `rsp_of`, `rsp_zero` and `rsp_slt` reflect whatever the ALU drives.
- `alu_op/a/b` hold their last values in IDLE and RESP.

## Timing

- Reset values:
  - State IDLE, `last_grant` = N_REQ-1, so requester 0 wins first.
  - `req_ready`, `rsp_valid`, `rsp_*`, `rsp_id`, `busy` and `alu_a/b` are all 0.
  - `alu_op` is 4'b1111, which selects the ALU zero default.
- Latency for a request accepted at cycle T:
  - The ALU inputs are valid from T+1.
  - `rsp_valid` rises at T+2 for non-multiply ops.
  - `rsp_valid` rises at T+2+`MUL_WAIT` for multiply.
- If `rsp_ready` is high when `rsp_valid` rises, the next grant is at T+3 at the earliest. Throughput is one op per 3 cycles (non-multiply).
- Simultaneous `req_valid` bits: the arbiter grants one requester per IDLE cycle and rotates fairly; no requester waits more than N_REQ-1 grants.
- Reset mid-EXEC or mid-RESP: the in-flight op is dropped, no response is issued, and the next cycle is IDLE with `last_grant` reset.

## Structure

- Package `alu_ctrl_pkg` holds:
  - Opcode constants `OP_INV`=4'b0000 .. `OP_RR`=4'b1000, `OP_ADD`=4'b1001, `OP_SUB`=4'b1010, `OP_MUL`=4'b1011.
  - The state encoding (IDLE/EXEC/RESP).
- One sub-module, `rr_arbiter`:
  - Inputs: `req[N_REQ-1:0]`, `last_grant`.
  - Outputs: one-hot `grant` and its index.
  - Purely combinational; the `last_grant` register lives in the controller.

## Test plan

- Req0 ADD a=0x05 b=0x03, accepted at T, `rsp_ready`=1 → `rsp_valid` at T+2, `rsp_result`=0x08, `rsp_id`=0, `rsp_of`=0, `rsp_err`=0; `busy` falls at T+3.
- Req1 SUB a=0x03 b=0x05 → `rsp_result`=0xFE, `rsp_slt`=1, `rsp_of`=0, `rsp_id`=1.
- Req0 MUL a=0xFD b=0x04 with `MUL_WAIT`=1 → `rsp_valid` at T+3, `rsp_product`=0xFFF4, `rsp_result`=0x00.
- Both requesters hold `req_valid` through 6 ops, `rsp_ready`=1 → grant order 0,1,0,1,0,1 and grants spaced 3 cycles.
- `rsp_ready` held 0 for 5 cycles in RESP → `rsp_*` stable, `req_ready` stays 0 despite `req_valid`=2'b11.
- Op 4'b1101 → `rsp_result`=0, `rsp_err`=1. Reset asserted during a MUL EXEC → no `rsp_valid`; after release, with both requesting, requester 0 is granted first.
